// File: rtl/sram_mem_stage_ctrl.sv
// MEM-stage controller: splits a 32-bit load/store into two 16-bit async SRAM accesses, freezing the pipeline until done.
// Optional one-entry last-read cache enabled by defining SRAM_CTRL_LAST_READ_CACHE_EN.
module sram_mem_stage_ctrl #(
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [15:0]        sram_dq,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int WW = SRAM_AW - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_op_q, wr_op_d;
    logic [WW-1:0]   word_q;
    logic [31:0]     wdata_q;
    logic [31:0]     read_data_q;
    logic            req, phase_end, hit;
    logic            dq_oe;
    logic [15:0]     dq_out;

    assign req       = rd_en | wr_en;
    assign phase_end = (cnt_q == CNT_LAST);

`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
    logic        c_valid_q;
    logic [31:0] c_tag_q, c_data_q, addr_q;

    assign hit = rd_en & ~wr_en & c_valid_q & (c_tag_q == address);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_valid_q <= 1'b0;
            c_tag_q   <= '0;
            c_data_q  <= '0;
            addr_q    <= '0;
        end else begin
            if (state_q == IDLE)
                addr_q <= address;
            // Upper half arrives on the bus in the same edge the read completes
            if (state_q == HIGH && phase_end && !wr_op_q) begin
                c_valid_q <= 1'b1;
                c_tag_q   <= addr_q;
                c_data_q  <= {sram_dq, read_data_q[15:0]};
            end else if (state_q == HIGH && phase_end && wr_op_q && c_valid_q && c_tag_q == addr_q) begin
                c_data_q  <= wdata_q;
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Request operands are latched while idle; the pipeline is frozen afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_op_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_op_q <= wr_op_d;
            if (state_q == IDLE) begin
                word_q  <= WW'((address - 32'(ADDR_BASE)) >> 2);
                wdata_q <= write_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_op_d = wr_op_q;
        case (state_q)
            IDLE: if (req) begin
                wr_op_d = wr_en;
                cnt_d   = '0;
                state_d = hit ? DONE : LOW;
            end
            LOW: if (phase_end) begin
                cnt_d   = '0;
                state_d = HIGH;
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
            HIGH: if (phase_end) begin
                cnt_d   = '0;
                state_d = DONE;
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state_q == DONE) | ((state_q == IDLE) & ~req);
        sram_addr = '0;
        sram_we_n = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = wdata_q[15:0];
        case (state_q)
            LOW: begin
                sram_addr = {word_q, 1'b0};
                sram_we_n = ~wr_op_q;
                dq_oe     = wr_op_q;
            end
            HIGH: begin
                sram_addr = {word_q, 1'b1};
                sram_we_n = ~wr_op_q;
                dq_oe     = wr_op_q;
                dq_out    = wdata_q[31:16];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            read_data_q <= '0;
        else if (state_q == LOW && phase_end && !wr_op_q)
            read_data_q[15:0] <= sram_dq;
        else if (state_q == HIGH && phase_end && !wr_op_q)
            read_data_q[31:16] <= sram_dq;
`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
        else if (state_q == IDLE && hit)
            read_data_q <= c_data_q;
`endif
    end

    assign read_data = read_data_q;
    assign sram_dq   = dq_oe ? dq_out : 16'bz;
    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_mem_stage_ctrl.sv
// Bench for sram_mem_stage_ctrl: directed loads/stores against a behavioural SRAM,
// a per-cycle transaction model, and hand-computed literal results.
module tb_sram_mem_stage_ctrl;
    localparam int W    = 2;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;

    int n_chk = 0, n_pass = 0;

    sram_mem_stage_ctrl dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready), .sram_dq(sram_dq),
        .sram_addr(sram_addr), .sram_we_n(sram_we_n),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #5 clk = ~clk;

    // Async SRAM with CE/OE tied active: drives whenever not being written
    logic [15:0] mem [0:255];
    assign sram_dq = sram_we_n ? mem[sram_addr[7:0]] : 16'hzzzz;
    always @(posedge clk) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    // Transaction-level model: k counts cycles since the request was first seen
    logic [15:0] ref_mem [0:255];
    logic        busy = 1'b0, m_wr = 1'b0, m_hit = 1'b0;
    int          k = 0;
    logic [31:0] m_word = '0, m_data = '0, m_addr = '0, exp_rd = '0;
`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
    logic        c_valid = 1'b0;
    logic [31:0] c_tag = '0, c_data = '0;
`endif

    function automatic logic [17:0] sa(input logic [31:0] w, input logic h);
        return 18'((w << 1) + 32'(h));
    endfunction

    always @(negedge clk) begin
        logic        e_rdy, e_wen;
        logic [17:0] e_a;
        logic [15:0] e_dq;
        e_rdy = 1'b1; e_wen = 1'b1; e_a = '0;
        if (rst) begin
            busy = 1'b0; exp_rd = '0;
`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
            c_valid = 1'b0;
`endif
            e_rdy = !(rd_en || wr_en);
        end else begin
            if (!busy && (rd_en || wr_en)) begin
                busy = 1'b1; k = 0; m_wr = wr_en; m_addr = address;
                m_data = write_data; m_word = (address - BASE) >> 2;
                m_hit = 1'b0;
`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
                m_hit = !wr_en && c_valid && (c_tag == address);
`endif
            end
            if (busy) begin
                e_rdy = m_hit ? (k == 1) : (k == 2*W+1);
                if (!m_hit && k >= 1 && k <= 2*W) begin
                    e_a   = sa(m_word, k > W);
                    e_wen = !m_wr;
                end
            end
        end
        e_dq = e_wen ? ref_mem[e_a[7:0]] : ((k > W) ? m_data[31:16] : m_data[15:0]);
        chk("ready", ready, e_rdy);
        chk("read_data", read_data, exp_rd);
        chk("we_n", sram_we_n, e_wen);
        chk("addr", sram_addr, e_a);
        chk("dq", sram_dq, e_dq);
        if (!rst && busy) begin
            if (m_hit) begin
`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
                if (k == 0) exp_rd = c_data;
`endif
            end else begin
                logic [17:0] lo, hi;
                lo = sa(m_word, 1'b0); hi = sa(m_word, 1'b1);
                if (!m_wr && k == W) exp_rd[15:0] = ref_mem[lo[7:0]];
                if (k == 2*W) begin
                    if (m_wr) begin
                        ref_mem[lo[7:0]] = m_data[15:0];
                        ref_mem[hi[7:0]] = m_data[31:16];
`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
                        if (c_valid && c_tag == m_addr) c_data = m_data;
`endif
                    end else begin
                        exp_rd[31:16] = ref_mem[hi[7:0]];
`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
                        c_valid = 1'b1; c_tag = m_addr; c_data = exp_rd;
`endif
                    end
                end
            end
            if (k == (m_hit ? 1 : 2*W+1)) busy = 1'b0;
            k++;
        end
    end

    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int lat);
        @(posedge clk); #1;
        rd_en = r; wr_en = w; address = a; write_data = d;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) begin lat = i; break; end
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    int lat, hit_lat;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'hA5C3 ^ 16'(i);
            ref_mem[i] = 16'hA5C3 ^ 16'(i);
        end
`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
        hit_lat = 1;
`else
        hit_lat = 5;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", ready, 1);
        chk("idle_read_data", read_data, 32'h0);
        chk("idle_we_n", sram_we_n, 1);
        chk("idle_dq_undriven", sram_dq, 16'hA5C3);
        chk("tied_ctrl", {sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}, 4'b0000);

        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lat);
        chk("wr_latency", lat, 5);
        chk("wr_mem0", mem[0], 16'hBEEF);
        chk("wr_mem1", mem[1], 16'hDEAD);

        access(1'b1, 1'b0, 32'd1024, 32'h0, lat);
        chk("rd_latency", lat, 5);
        chk("rd_data", read_data, 32'hDEADBEEF);

        access(1'b0, 1'b1, 32'd1032, 32'h12345678, lat);
        chk("wr_mem4", mem[4], 16'h5678);
        chk("wr_mem5", mem[5], 16'h1234);

        access(1'b1, 1'b1, 32'd1036, 32'hA1B2C3D4, lat);
        chk("rdwr_latency", lat, 5);
        chk("rdwr_mem6", mem[6], 16'hC3D4);
        chk("rdwr_mem7", mem[7], 16'hA1B2);
        chk("rdwr_hold", read_data, 32'hDEADBEEF);

        access(1'b1, 1'b0, 32'd1032, 32'h0, lat);
        chk("rd1032", read_data, 32'h12345678);

        // Abort a read in its first HIGH cycle
        @(posedge clk); #1;
        rd_en = 1'b1; address = 32'd1024;
        repeat (W+1) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_addr", sram_addr, 18'h0);
        chk("rst_dq_undriven", sram_dq, 16'hBEEF);
        chk("rst_ready_req", ready, 0);
        rd_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        access(1'b1, 1'b0, 32'd1036, 32'h0, lat);
        chk("post_rst_latency", lat, 5);
        chk("post_rst_data", read_data, 32'hA1B2C3D4);

        access(1'b1, 1'b0, 32'd1024, 32'h0, lat);
        chk("rd_a_latency", lat, 5);
        access(1'b1, 1'b0, 32'd1024, 32'h0, lat);
        chk("rd_b_latency", lat, hit_lat);
        chk("rd_b_data", read_data, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, lat);
        chk("wr_cafe_mem0", mem[0], 16'hF00D);
        access(1'b1, 1'b0, 32'd1024, 32'h0, lat);
        chk("rd_cafe_latency", lat, hit_lat);
        chk("rd_cafe_data", read_data, 32'hCAFEF00D);

        // 1020 is below the base: word wraps, SRAM address truncates to 0x3FFFE/0x3FFFF
        access(1'b1, 1'b0, 32'd1020, 32'h0, lat);
        chk("wrap_data", read_data, 32'hA53CA53D);

        @(negedge clk);
        chk("final_ready", ready, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
